// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM states, opcode classes,
// vector addresses and PC-source encodings.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    RST_HI,
    RST_LO,
    FETCH,
    IMM,
    INT_HI,
    INT_LO
  } fetch_state_t;

  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [4:0] OP_IADD = 5'b00110;
  localparam logic [4:0] OP_LDM  = 5'b01100;
  localparam logic [4:0] OP_LDD  = 5'b01101;
  localparam logic [4:0] OP_STD  = 5'b01110;

  localparam logic [31:0] RESET_VEC_ADDR = 32'd0;
  localparam logic [31:0] INT_VEC_ADDR   = 32'd2;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_STACK  = 2'b10;

  // Opcodes that carry a second (immediate) word.
  function automatic logic is_imm_opcode(input logic [4:0] opcode);
    return (opcode == OP_IADD) || (opcode == OP_LDM) ||
           (opcode == OP_LDD)  || (opcode == OP_STD);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: redirect, 16-bit half loads from the vector words,
// increment, or hold. Redirect has highest priority.
module pc_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_load_hi,
  input  logic        i_load_lo,
  input  logic        i_incr,
  input  logic [15:0] i_word,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect)
      w_pc_next = i_redirect_pc;
    else if (i_load_hi)
      w_pc_next = {i_word, r_pc[15:0]};
    else if (i_load_lo)
      w_pc_next = {r_pc[31:16], i_word};
    else if (i_incr)
      w_pc_next = r_pc + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pc <= RESET_VEC_ADDR;
    else
      r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: boot/interrupt vector loading, two-word instruction
// assembly and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_pc_enable,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] pc_jmp,
  input  logic [31:0] stack_pc,
  input  logic        interrupt,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] immediate,
  output logic [31:0] pc_next,
  output logic        if_valid,
  output logic        int_ack
);

  fetch_state_t r_state;
  logic [15:0]  r_pending;
  logic [15:0]  r_instruction;
  logic [15:0]  r_immediate;
  logic [31:0]  r_pc_next;
  logic         r_if_valid;
  logic         r_int_ack;

  logic [31:0]  w_pc;
  logic         w_redirect;
  logic [31:0]  w_redirect_pc;
  logic         w_advance;
  logic         w_int_accept;
  logic         w_deliver;
  logic         w_if_load;
  logic [15:0]  w_instr;

  assign w_redirect    = (pc_sel == PC_SEL_STACK) ||
                         ((pc_sel == PC_SEL_BRANCH) && branch_taken);
  assign w_redirect_pc = (pc_sel == PC_SEL_STACK) ? stack_pc : pc_jmp;
  // Normal sequencing only proceeds when nothing of higher priority intervenes.
  assign w_advance     = !w_redirect && !stall && fetch_pc_enable;
  assign w_int_accept  = w_advance && (r_state == FETCH) && interrupt;
  assign w_deliver     = w_advance &&
                         (((r_state == FETCH) && !interrupt && !is_imm_opcode(imem_rdata[15:11])) ||
                          (r_state == IMM));
  assign w_if_load     = w_redirect || !stall;
  assign w_instr       = (r_state == IMM) ? r_pending : imem_rdata;

  pc_reg u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (w_redirect),
    .i_redirect_pc (w_redirect_pc),
    .i_load_hi     (w_advance && ((r_state == RST_HI) || (r_state == INT_HI))),
    .i_load_lo     (w_advance && ((r_state == RST_LO) || (r_state == INT_LO))),
    .i_incr        (w_advance && (((r_state == FETCH) && !interrupt) || (r_state == IMM))),
    .i_word        (imem_rdata),
    .o_pc          (w_pc)
  );

  always_comb begin
    case (r_state)
      RST_HI:  imem_addr = RESET_VEC_ADDR;
      RST_LO:  imem_addr = RESET_VEC_ADDR + 32'd1;
      INT_HI:  imem_addr = INT_VEC_ADDR;
      INT_LO:  imem_addr = INT_VEC_ADDR + 32'd1;
      default: imem_addr = w_pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RST_HI;
      r_pending     <= NOP;
      r_instruction <= NOP;
      r_immediate   <= '0;
      r_pc_next     <= '0;
      r_if_valid    <= 1'b0;
      r_int_ack     <= 1'b0;
    end else begin
      r_int_ack <= w_int_accept;
      // Any update that is not a delivery is a bubble; pc_next keeps its value
      // except when an interrupt captures the unfetched return address.
      if (w_if_load) begin
        r_if_valid    <= w_deliver;
        r_instruction <= w_deliver ? w_instr : NOP;
        r_immediate   <= (w_deliver && (r_state == IMM)) ? imem_rdata : '0;
        if (w_deliver)
          r_pc_next <= w_pc + 32'd1;
        else if (w_int_accept)
          r_pc_next <= w_pc;
      end
      if (w_redirect) begin
        r_state   <= FETCH;
        r_pending <= NOP;
      end else if (w_advance) begin
        case (r_state)
          RST_HI: r_state <= RST_LO;
          RST_LO: r_state <= FETCH;
          FETCH: begin
            if (interrupt) begin
              r_state <= INT_HI;
            end else if (is_imm_opcode(imem_rdata[15:11])) begin
              r_pending <= imem_rdata;
              r_state   <= IMM;
            end
          end
          IMM:     r_state <= FETCH;
          INT_HI:  r_state <= INT_LO;
          INT_LO:  r_state <= FETCH;
          default: r_state <= RST_HI;
        endcase
      end
    end
  end

  assign instruction = r_instruction;
  assign immediate   = r_immediate;
  assign pc_next     = r_pc_next;
  assign if_valid    = r_if_valid;
  assign int_ack     = r_int_ack;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 stall  in  1  load-use stall; hold PC and the IF/ID register.
REQ-004 fetch_pc_enable  in  1  0 = hold PC and insert a bubble into IF/ID.
REQ-005 pc_sel  in  2  00 sequential, 01 branch target, 10 stack-popped PC, 11 treated as 00.
REQ-006 branch_taken  in  1  qualifies pc_sel=01.
REQ-007 pc_jmp  in  32  branch/jump target.
REQ-008 stack_pc  in  32  PC assembled from the stack (ret/rti).
REQ-009 interrupt  in  1  level request, sampled only in FETCH.
REQ-010 imem_addr  out  32  instruction-memory word address.
REQ-011 imem_rdata  in  16  instruction word; combinational read of imem_addr in the same cycle.
REQ-012 instruction  out  16  IF/ID opcode word to decode.
REQ-013 immediate  out  16  IF/ID second word of a two-word instruction, else 0.
REQ-014 pc_next  out  32  IF/ID address following the delivered instruction (call/interrupt push value).
REQ-015 if_valid  out  1  IF/ID holds a real instruction.
REQ-016 int_ack  out  1  one-cycle pulse when an interrupt is accepted.

Function
REQ-017 FSM states: RST_HI, RST_LO, FETCH, IMM, INT_HI, INT_LO.
REQ-018 imem_addr: 0 in RST_HI, 1 in RST_LO, 2 in INT_HI, 3 in INT_LO, PC otherwise.
REQ-019 RST_HI: PC[31:16] <= imem_rdata, go to RST_LO. RST_LO: PC[15:0] <= imem_rdata, go to FETCH. IF/ID is a bubble throughout.
REQ-020 FETCH with a single-word opcode: instruction <= imem_rdata, immediate <= 0, pc_next <= PC+1, if_valid <= 1, PC <= PC+1.
REQ-021 FETCH with opcode imem_rdata[15:11] in IMM_OPCODES: latch the word into a pending register, PC <= PC+1, IF/ID bubble, go to IMM.
REQ-022 IMM: instruction <= pending, immediate <= imem_rdata, pc_next <= PC+1, if_valid <= 1, PC <= PC+1, go to FETCH.
REQ-023 Bubble: instruction = 16'h0000, immediate = 0, if_valid = 0; pc_next is held.
REQ-024 Redirect: pc_sel=10, or pc_sel=01 with branch_taken=1. PC <= stack_pc or pc_jmp respectively, IF/ID bubbled next cycle, pending discarded, state goes to FETCH.
REQ-025 Priority, highest first: rst, redirect, stall, fetch_pc_enable=0, interrupt, normal sequencing.
REQ-026 stall=1 without redirect: PC, state, pending and IF/ID all hold.
REQ-027 fetch_pc_enable=0 without redirect or stall: PC and state hold, IF/ID bubbled.
REQ-028 interrupt=1 in FETCH, no higher-priority event:
  - int_ack=1 for that cycle; pc_next <= PC (the unfetched return address); IF/ID bubble; go to INT_HI.
  - INT_HI/INT_LO load PC[31:16]/PC[15:0] from words 2/3, then go to FETCH.
  - interrupt is ignored in IMM, INT_*, RST_*.
REQ-029 PC arithmetic is 32-bit modulo: 32'hFFFFFFFF+1 = 0.

Reset
REQ-030 rst=1 forces immediately, without a clock edge: state=RST_HI, PC=0, pending=0, instruction=0, immediate=0, pc_next=0, if_valid=0, int_ack=0.
REQ-031 A reset asserted mid-IMM or mid-INT discards the partial instruction or vector; after release the boot sequence restarts at RST_HI.

Structure
REQ-032 A shared pipeline package holds:
  - the FSM state enum;
  - NOP=16'h0000;
  - IMM_OPCODES = {5'b00110 IADD, 5'b01100 LDM, 5'b01101 LDD, 5'b01110 STD};
  - reset vector word address 0 and interrupt vector word address 2;
  - pc_sel encodings.
REQ-033 One sub-module, pc_reg: the 32-bit PC with next-PC mux and hold logic; the FSM and IF/ID register stay in fetch_stage.

Verification
REQ-034 Boot with M[0]=0x0000, M[1]=0x0020 -> imem_addr 0, 1, 0x20 on cycles 1-3; first if_valid=1 at cycle 4 with instruction=M[0x20].
REQ-035 LDM at 0x20, M[0x21]=0xBEEF -> one bubble, then instruction=LDM word, immediate=0xBEEF, pc_next=0x22, if_valid=1.
REQ-036 stall held 2 cycles at PC=0x24 -> imem_addr stays 0x24 and IF/ID is unchanged for both cycles; sequencing resumes at 0x25.
REQ-037 pc_sel=01, branch_taken=1, pc_jmp=0x40, with stall=1 in the same cycle -> PC=0x40, if_valid=0 next cycle; redirect wins over stall.
REQ-038 interrupt in FETCH at PC=0x30, M[2]=0, M[3]=0x100 -> int_ack pulse, pc_next=0x30, addresses 2 then 3 read, then fetch from 0x100.
REQ-039 rst asserted while in IMM -> all outputs 0 asynchronously; after release the bench sees the boot sequence from REQ-034 again.
